src_stream_ctrl: RTL and testbench

SRC_STREAM_CTRL -- requirements
Module: src_stream_ctrl

---
 rtl/src_stream_if.sv | 34 +++
 rtl/src_stream_ctrl.sv | 118 +++++++++++
 tb/tb_src_stream_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/src_stream_if.sv
// Handshake bundle between the stream controller and its producers and downstream buffer.
// The master modport is the controller's view; the slave modport is the environment's view.
interface src_stream_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned N_CH   = 4
);
    localparam int unsigned CH_W = ($clog2(N_CH) < 1) ? 1 : $clog2(N_CH);

    logic [N_CH-1:0]        start;
    logic                   stop;
    logic [N_CH-1:0]        src_valid;
    logic [N_CH*DATA_W-1:0] src_data;
    logic                   buf_full;
    logic                   buf_empty;
    logic                   rd_valid;
    logic [N_CH-1:0]        src_en;
    logic                   wr_en;
    logic [DATA_W-1:0]      wr_data;
    logic                   wr_par;
    logic [CH_W-1:0]        active_ch;
    logic [1:0]             state;
    logic [15:0]            word_cnt;
    logic                   ovf;

    modport master (
        input  start, stop, src_valid, src_data, buf_full, buf_empty, rd_valid,
        output src_en, wr_en, wr_data, wr_par, active_ch, state, word_cnt, ovf
    );

    modport slave (
        output start, stop, src_valid, src_data, buf_full, buf_empty, rd_valid,
        input  src_en, wr_en, wr_data, wr_par, active_ch, state, word_cnt, ovf
    );
endinterface

// File: rtl/src_stream_ctrl.sv
// Selects one producer channel and streams its words into a downstream buffer, with stall/drain.
// Optional parity on wr_par is built only when SRC_STREAM_PARITY_EN is defined.
module src_stream_ctrl #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned N_CH   = 4
) (
    input  logic          clk,
    input  logic          rst,
    src_stream_if.master  bus
);
    localparam int unsigned CH_W = ($clog2(N_CH) < 1) ? 1 : $clog2(N_CH);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StHold  = 2'd2,
        StDrain = 2'd3
    } state_e;

    state_e            state_q;
    logic [N_CH-1:0]   src_en_q;
    logic              wr_en_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [CH_W-1:0]   active_q;
    logic [15:0]       cnt_q;
    logic              ovf_q;

    logic [CH_W-1:0]   first_ch_d;
    logic              sel_valid;
    logic [DATA_W-1:0] sel_word;

    // Lowest-index start request wins.
    always_comb begin
        first_ch_d = '0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (bus.start[i]) first_ch_d = CH_W'(i);
        end
    end

    assign sel_valid = bus.src_valid[active_q];
    assign sel_word  = bus.src_data[active_q*DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            src_en_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            active_q  <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (|bus.start) begin
                        active_q <= first_ch_d;
                        cnt_q    <= '0;
                        ovf_q    <= 1'b0;
                        src_en_q <= N_CH'(1) << first_ch_d;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    if (bus.stop) begin
                        src_en_q <= '0;
                        state_q  <= StDrain;
                    end else if (bus.buf_full) begin
                        // The word offered while the buffer fills is lost.
                        src_en_q <= '0;
                        state_q  <= StHold;
                        if (sel_valid) ovf_q <= 1'b1;
                    end else if (sel_valid) begin
                        wr_en_q   <= 1'b1;
                        wr_data_q <= sel_word;
                        cnt_q     <= cnt_q + 16'd1;
                    end
                end
                StHold: begin
                    if (bus.stop) begin
                        state_q <= StDrain;
                    end else if (!bus.buf_full) begin
                        src_en_q <= N_CH'(1) << active_q;
                        state_q  <= StRun;
                    end
                end
                StDrain: begin
                    if (bus.buf_empty && !bus.rd_valid) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef SRC_STREAM_PARITY_EN
    logic wr_par_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_par_q <= 1'b0;
        end else if (state_q == StRun && !bus.stop && !bus.buf_full && sel_valid) begin
            wr_par_q <= ^sel_word;
        end
    end

    assign bus.wr_par = wr_par_q;
`else
    assign bus.wr_par = 1'b0;
`endif

    assign bus.state     = state_q;
    assign bus.src_en    = src_en_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.active_ch = active_q;
    assign bus.word_cnt  = cnt_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_src_stream_ctrl.sv
// Bench for src_stream_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_src_stream_ctrl;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned N_CH   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    src_stream_if #(.DATA_W(DATA_W), .N_CH(N_CH)) bus ();

    src_stream_ctrl #(.DATA_W(DATA_W), .N_CH(N_CH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int err_cnt = 0;
    int chk_cnt = 0;

    // Reference model state.
    int                m_state;
    int                m_ch;
    int                m_cnt;
    logic [N_CH-1:0]   m_en;
    logic              m_wr;
    logic [DATA_W-1:0] m_data;
    logic              m_ovf;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [N_CH-1:0] lsb;
        if (rst) begin
            m_state = 0; m_ch = 0; m_cnt = 0; m_en = '0; m_wr = 1'b0; m_data = '0; m_ovf = 1'b0;
            return;
        end
        m_wr = 1'b0;
        case (m_state)
            0: if (bus.start != '0) begin
                lsb     = bus.start & (~bus.start + 1'b1);
                m_ch    = $clog2(lsb);
                m_cnt   = 0;
                m_ovf   = 1'b0;
                m_state = 1;
            end
            1: if (bus.stop) m_state = 3;
            else if (bus.buf_full) begin
                m_state = 2;
                if (bus.src_valid[m_ch]) m_ovf = 1'b1;
            end else if (bus.src_valid[m_ch]) begin
                m_wr   = 1'b1;
                m_data = DATA_W'(bus.src_data >> (m_ch * DATA_W));
                m_cnt  = (m_cnt + 1) % 65536;
            end
            2: if (bus.stop) m_state = 3;
            else if (!bus.buf_full) m_state = 1;
            default: if (bus.buf_empty && !bus.rd_valid) m_state = 0;
        endcase
        m_en = (m_state == 1) ? N_CH'(1 << m_ch) : '0;
    endtask

    task automatic check_all();
        logic exp_par;
`ifdef SRC_STREAM_PARITY_EN
        exp_par = ^m_data;
`else
        exp_par = 1'b0;
`endif
        check_eq("state", 32'(bus.state), 32'(m_state));
        check_eq("src_en", 32'(bus.src_en), 32'(m_en));
        check_eq("wr_en", 32'(bus.wr_en), 32'(m_wr));
        check_eq("wr_data", 32'(bus.wr_data), 32'(m_data));
        check_eq("wr_par", 32'(bus.wr_par), 32'(exp_par));
        check_eq("active_ch", 32'(bus.active_ch), 32'(m_ch));
        check_eq("word_cnt", 32'(bus.word_cnt), 32'(m_cnt));
        check_eq("ovf", 32'(bus.ovf), 32'(m_ovf));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic quiet_inputs();
        bus.start = '0; bus.stop = 1'b0; bus.src_valid = '0; bus.src_data = '0;
        bus.buf_full = 1'b0; bus.buf_empty = 1'b0; bus.rd_valid = 1'b0;
    endtask

    int pulses;

    initial begin
        quiet_inputs();
        rst = 1'b1;
        tick();
        tick();
        check_eq("rst_state", 32'(bus.state), 32'd0);
        check_eq("rst_wr_data", 32'(bus.wr_data), 32'd0);
        rst = 1'b0;

        // Lowest set start bit selects channel 1.
        bus.start = 4'b0110;
        tick();
        bus.start = '0;
        check_eq("sel_ch", 32'(bus.active_ch), 32'd1);
        check_eq("sel_en", 32'(bus.src_en), 32'h2);
        check_eq("sel_state", 32'(bus.state), 32'd1);

        // Three back-to-back words from channel 1.
        bus.src_valid = 4'b0010;
        bus.src_data  = {16'h0000, 16'h0000, 16'h00A5, 16'h0000};
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.wr_en) pulses++;
        end
        bus.src_valid = '0;
        tick();
        check_eq("burst_pulses", 32'(pulses), 32'd3);
        check_eq("burst_wr_en_off", 32'(bus.wr_en), 32'd0);
        check_eq("burst_data", 32'(bus.wr_data), 32'h00A5);
        check_eq("burst_cnt", 32'(bus.word_cnt), 32'd3);
        check_eq("burst_par", 32'(bus.wr_par), 32'd0);

        // Buffer full while a word is offered.
        bus.src_valid = 4'b0010;
        bus.buf_full  = 1'b1;
        tick();
        check_eq("full_state", 32'(bus.state), 32'd2);
        check_eq("full_en", 32'(bus.src_en), 32'd0);
        check_eq("full_wr", 32'(bus.wr_en), 32'd0);
        check_eq("full_ovf", 32'(bus.ovf), 32'd1);
        for (int i = 0; i < 3; i++) tick();
        bus.buf_full = 1'b0;
        tick();
        check_eq("resume_state", 32'(bus.state), 32'd1);
        tick();
        check_eq("resume_wr", 32'(bus.wr_en), 32'd1);
        check_eq("resume_cnt", 32'(bus.word_cnt), 32'd4);
        bus.src_valid = '0;

        // Stop beats buf_full; drain waits for an idle read side.
        bus.stop = 1'b1; bus.buf_full = 1'b1;
        tick();
        check_eq("stop_state", 32'(bus.state), 32'd3);
        check_eq("stop_wr", 32'(bus.wr_en), 32'd0);
        bus.stop = 1'b0; bus.buf_full = 1'b0; bus.buf_empty = 1'b1; bus.rd_valid = 1'b1;
        tick();
        check_eq("drain_hold", 32'(bus.state), 32'd3);
        bus.rd_valid = 1'b0;
        tick();
        check_eq("drain_exit", 32'(bus.state), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            rst           = ($urandom_range(0, 99) == 0);
            bus.start     = N_CH'($urandom);
            bus.stop      = ($urandom_range(0, 19) == 0);
            bus.src_valid = N_CH'($urandom);
            bus.src_data  = {$urandom, $urandom};
            bus.buf_full  = ($urandom_range(0, 3) == 0);
            bus.buf_empty = 1'($urandom);
            bus.rd_valid  = 1'($urandom);
            tick();
        end

        // Counter wrap on channel 0.
        quiet_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.start = 4'b0001;
        tick();
        bus.start = '0;
        bus.src_valid = 4'b0001;
        for (int i = 0; i < 65535; i++) begin
            bus.src_data = {$urandom, $urandom};
            tick();
        end
        check_eq("pre_wrap_cnt", 32'(bus.word_cnt), 32'hFFFF);
        tick();
        check_eq("wrap_cnt", 32'(bus.word_cnt), 32'd0);
        check_eq("wrap_ovf", 32'(bus.ovf), 32'd0);
        check_eq("wrap_wr", 32'(bus.wr_en), 32'd1);

        // Reset mid-stream, then restart on channel 3.
        rst = 1'b1;
        tick();
        check_eq("midrst_state", 32'(bus.state), 32'd0);
        check_eq("midrst_wr", 32'(bus.wr_en), 32'd0);
        check_eq("midrst_en", 32'(bus.src_en), 32'd0);
        check_eq("midrst_data", 32'(bus.wr_data), 32'd0);
        rst = 1'b0;
        bus.src_valid = '0;
        bus.start = 4'b1000;
        tick();
        bus.start = '0;
        check_eq("restart_ch", 32'(bus.active_ch), 32'd3);
        check_eq("restart_en", 32'(bus.src_en), 32'h8);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
